// File: rtl/obi_data_arbiter.sv
// Two-master to one-slave OBI data-port arbiter with in-order response routing.
// Zero added latency on both phases; requests stall (s_req_o low) while the ID FIFO is full.
module obi_data_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int PRIO_MODE       = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    s_req_o,
    input  logic                    s_gnt_i,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    input  logic                    s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,
    output logic                    protocol_err_o
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic                       lock;
    logic                       lock_sel;
    logic                       last_sel;
    logic                       err;
    logic [MAX_OUTSTANDING-1:0] id_mem;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              count;

    logic sel;
    logic full;
    logic empty;
    logic hs;
    logic pop;
    logic head;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // A stalled request keeps its master: OBI masters may not retract before gnt.
    always_comb begin
        sel = 1'b0;
        if (lock) begin
            sel = lock_sel;
        end else if (m0_req_i && m1_req_i) begin
            sel = (PRIO_MODE != 0) ? 1'b0 : ~last_sel;
        end else begin
            sel = m1_req_i;
        end
    end

    // full uses the registered count so rvalid never feeds gnt combinationally.
    assign full  = (count == CW'(MAX_OUTSTANDING));
    assign empty = (count == '0);
    assign head  = id_mem[rd_ptr];

    assign s_req_o = (m0_req_i | m1_req_i) & ~full;
    assign hs      = s_req_o & s_gnt_i;
    assign pop     = s_rvalid_i & ~empty;

    assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = sel ? m1_we_i    : m0_we_i;
    assign s_be_o    = sel ? m1_be_i    : m0_be_i;
    assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

    assign m0_gnt_o = hs & ~sel;
    assign m1_gnt_o = hs &  sel;

    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop &  head;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;

    assign protocol_err_o = err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock     <= 1'b0;
            lock_sel <= 1'b0;
            last_sel <= 1'b1;
            err      <= 1'b0;
            id_mem   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (hs) begin
                lock           <= 1'b0;
                last_sel       <= sel;
                id_mem[wr_ptr] <= sel;
                wr_ptr         <= ptr_next(wr_ptr);
            end else if (s_req_o) begin
                lock     <= 1'b1;
                lock_sel <= sel;
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (hs && !pop) begin
                count <= count + 1'b1;
            end else if (!hs && pop) begin
                count <= count - 1'b1;
            end
            if (s_rvalid_i && empty) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Bench for obi_data_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each tracked by a queue-based reference model.
module tb_obi_data_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m0_req, m1_req, m0_we, m1_we, s_gnt, s_rvalid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
    logic [3:0]  m0_be, m1_be;

    logic [1:0]  o_sreq, o_g0, o_g1, o_rv0, o_rv1, o_err, o_we;
    logic [31:0] o_addr [2];
    logic [31:0] o_wdata [2];
    logic [31:0] o_rd0 [2];
    logic [31:0] o_rd1 [2];
    logic [3:0]  o_be [2];

    always #5 clk_i = ~clk_i;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        obi_data_arbiter #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .PRIO_MODE(k)
        ) dut (
            .clk_i(clk_i), .rst_ni(rst_ni),
            .m0_req_i(m0_req), .m0_gnt_o(o_g0[k]), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
            .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(o_rv0[k]), .m0_rdata_o(o_rd0[k]),
            .m1_req_i(m1_req), .m1_gnt_o(o_g1[k]), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
            .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(o_rv1[k]), .m1_rdata_o(o_rd1[k]),
            .s_req_o(o_sreq[k]), .s_gnt_i(s_gnt), .s_addr_o(o_addr[k]), .s_we_o(o_we[k]),
            .s_be_o(o_be[k]), .s_wdata_o(o_wdata[k]), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
            .protocol_err_o(o_err[k])
        );
    end

    // Reference model, index 0 = round-robin instance, 1 = fixed-priority instance.
    bit mq [2][$];
    bit m_last [2];
    bit m_lock [2];
    bit m_lsel [2];
    bit m_err [2];
    bit e_sel [2];
    bit e_req [2];
    bit took0, took1;
    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_last[k] = 1'b1;
            m_lock[k] = 1'b0;
            m_lsel[k] = 1'b0;
            m_err[k]  = 1'b0;
        end
    endtask

    task automatic settle();
        bit s, hd, valid_head;
        #2;
        for (int k = 0; k < 2; k++) begin
            if (m_lock[k])             s = m_lsel[k];
            else if (m0_req && m1_req) s = (k == 1) ? 1'b0 : !m_last[k];
            else if (m1_req)           s = 1'b1;
            else                       s = 1'b0;
            e_sel[k] = s;
            e_req[k] = (m0_req || m1_req) && (mq[k].size() < 2);
            valid_head = s_rvalid && (mq[k].size() > 0);
            hd = (mq[k].size() > 0) ? mq[k][0] : 1'b0;
            chk($sformatf("s_req[%0d]", k), o_sreq[k], e_req[k]);
            chk($sformatf("gnt0[%0d]", k), o_g0[k], e_req[k] && s_gnt && !s);
            chk($sformatf("gnt1[%0d]", k), o_g1[k], e_req[k] && s_gnt && s);
            chk($sformatf("s_addr[%0d]", k), o_addr[k], s ? m1_addr : m0_addr);
            chk($sformatf("s_ctl[%0d]", k), {o_we[k], o_be[k], o_wdata[k]},
                s ? {m1_we, m1_be, m1_wdata} : {m0_we, m0_be, m0_wdata});
            chk($sformatf("rvalid0[%0d]", k), o_rv0[k], valid_head && !hd);
            chk($sformatf("rvalid1[%0d]", k), o_rv1[k], valid_head && hd);
            chk($sformatf("rdata[%0d]", k), {o_rd0[k], o_rd1[k]}, {s_rdata, s_rdata});
            chk($sformatf("err[%0d]", k), o_err[k], m_err[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        took0 = e_req[0] && s_gnt && !e_sel[0];
        took1 = e_req[0] && s_gnt && e_sel[0];
        for (int k = 0; k < 2; k++) begin
            if (s_rvalid) begin
                if (mq[k].size() > 0) mq[k].delete(0);
                else m_err[k] = 1'b1;
            end
            if (e_req[k] && s_gnt) begin
                mq[k].push_back(e_sel[k]);
                m_last[k] = e_sel[k];
                m_lock[k] = 1'b0;
            end else if (e_req[k]) begin
                m_lock[k] = 1'b1;
                m_lsel[k] = e_sel[k];
            end
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; s_gnt = 0; s_rvalid = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; m0_be = 0; m1_be = 0; s_rdata = 0;
        #2;
        chk("rst_outputs", {o_sreq, o_g0, o_g1, o_rv0, o_rv1}, 0);
        chk("rst_err", o_err, 0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single read from master 0.
        m0_req = 1; m0_addr = 32'h100; s_gnt = 1;
        settle(); chk("t1_gnt", o_g0[0], 1); tick();
        m0_req = 0; s_gnt = 0;
        settle(); tick();
        s_rvalid = 1; s_rdata = 32'hCAFE0000;
        settle();
        chk("t1_rvalid0", o_rv0[0], 1); chk("t1_rvalid1", o_rv1[0], 0);
        chk("t1_rdata", o_rd0[0], 32'hCAFE0000);
        tick(); s_rvalid = 0;

        // Round-robin alternation with back-to-back responses.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            m0_req = 1; m1_req = 1; m0_addr = 32'h1000 + i; m1_addr = 32'h2000 + i;
            s_gnt = 1; s_rvalid = (i > 0); s_rdata = i;
            settle();
            chk("t2_gnt0", o_g0[0], (i % 2) == 0);
            chk("t2_gnt1", o_g1[0], (i % 2) == 1);
            chk("t2_rv0", o_rv0[0], i > 0 && (i % 2) == 1);
            chk("t2_rv1", o_rv1[0], i > 0 && (i % 2) == 0);
            tick();
        end
        m0_req = 0; m1_req = 0; s_rvalid = 1;
        settle(); chk("t2_last_rv1", o_rv1[0], 1); tick();
        s_rvalid = 0;

        // Stalled m1 request keeps the port while m0 arrives.
        do_reset();
        m1_addr = 32'h200; m0_addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            m1_req = 1; m0_req = (i >= 1); s_gnt = (i == 3);
            settle();
            chk("t3_addr", o_addr[0], 32'h200);
            chk("t3_gnt0", o_g0[0], 0);
            chk("t3_gnt1", o_g1[0], i == 3);
            tick();
        end
        m1_req = 0;
        settle(); chk("t3_addr_m0", o_addr[0], 32'h300); chk("t3_gnt0_next", o_g0[0], 1); tick();
        m0_req = 0; s_gnt = 0; s_rvalid = 1;
        settle(); chk("t3_rv1", o_rv1[0], 1); tick();
        settle(); chk("t3_rv0", o_rv0[0], 1); tick();
        s_rvalid = 0;

        // FIFO full blocks requests; a pop unblocks only on the following cycle.
        do_reset();
        m0_req = 1; s_gnt = 1; m0_addr = 32'h400;
        settle(); tick();
        m0_addr = 32'h404;
        settle(); tick();
        m0_addr = 32'h408;
        settle(); chk("t4_full_req", o_sreq[0], 0); chk("t4_full_gnt", o_g0[0], 0); tick();
        s_rvalid = 1;
        settle(); chk("t4_pop_req", o_sreq[0], 0); chk("t4_pop_rv", o_rv0[0], 1); tick();
        s_rvalid = 0;
        settle(); chk("t4_reassert", o_sreq[0], 1); chk("t4_gnt", o_g0[0], 1); tick();
        m0_req = 0; s_rvalid = 1;
        settle(); tick();
        settle(); tick();
        s_rvalid = 0;

        // Fixed priority: master 0 always wins until it lets go.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m0_req = 1; m1_req = 1; s_gnt = 1; s_rvalid = (i > 0);
            settle(); chk("t5_gnt0", o_g0[1], 1); chk("t5_gnt1", o_g1[1], 0); tick();
        end
        m0_req = 0;
        settle(); chk("t5_m1_wins", o_g1[1], 1); tick();
        m1_req = 0;
        settle(); tick();
        s_rvalid = 0;

        // Stray response sets a sticky error.
        do_reset();
        s_rvalid = 1; s_rdata = 32'h5A5A;
        settle();
        chk("t6_rv0", o_rv0[0], 0); chk("t6_rv1", o_rv1[0], 0); chk("t6_err_same", o_err[0], 0);
        tick(); s_rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            settle(); chk("t6_err_sticky", o_err[0], 1); tick();
        end
        do_reset();
        m0_req = 1; s_gnt = 1;
        settle(); tick();
        do_reset();
        s_rvalid = 1;
        settle(); chk("t6_late_rv0", o_rv0[0], 0); tick();
        s_rvalid = 0;
        settle(); chk("t6_late_err", o_err[0], 1); tick();

        // Randomized traffic with OBI-legal masters driven from the round-robin instance.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if (i % 97 == 96) do_reset();
            if (!m0_req && $urandom_range(0, 2) == 0) begin
                m0_req = 1; m0_addr = $urandom; m0_we = 1'($urandom); m0_be = 4'($urandom);
                m0_wdata = $urandom;
            end
            if (!m1_req && $urandom_range(0, 2) == 0) begin
                m1_req = 1; m1_addr = $urandom; m1_we = 1'($urandom); m1_be = 4'($urandom);
                m1_wdata = $urandom;
            end
            s_gnt = ($urandom_range(0, 3) != 0);
            s_rvalid = (mq[0].size() > 0) && ($urandom_range(0, 1) == 1);
            s_rdata = $urandom;
            settle();
            tick();
            if (took0) m0_req = 0;
            if (took1) m1_req = 0;
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
